// File: rtl/g2b_defs.sv
// Shared definitions for the sequential Gray-to-binary decoder.
// State encodings and default word width.
package g2b_defs;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } g2b_state_t;

    localparam int G2B_WIDTH_DEF = 5;

endpackage

// File: rtl/g2b_seq.sv
// Sequential Gray-to-binary decoder: accepts a Gray word, resolves it MSB-first,
// one bit per clock, and presents the registered binary result.
//
// state  | meaning
// IDLE   | waiting for a Gray word (in_ready high)
// CONV   | resolving one bit per cycle, MSB first
// DONE   | result on binary, waiting for out_ready
module g2b_seq
    import g2b_defs::*;
#(
    parameter int WIDTH = G2B_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] gray,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] binary,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    g2b_state_t       state;
    logic [WIDTH-1:0] g_reg;
    logic [WIDTH-1:0] w;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH:0]   w_ext;
    logic [CNT_W-1:0] idx;

    // Zero pad above the MSB makes the MSB step reduce to w[msb] = g_reg[msb].
    assign w_ext = {1'b0, w};

    always_comb begin
        w_next = w;
        for (int i = 0; i < WIDTH; i++) begin
            if (idx == CNT_W'(i)) begin
                w_next[i] = w_ext[i+1] ^ g_reg[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            g_reg     <= '0;
            w         <= '0;
            idx       <= '0;
            binary    <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        g_reg    <= gray;
                        idx      <= CNT_W'(WIDTH - 1);
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= S_CONV;
                    end
                end
                S_CONV: begin
                    w <= w_next;
                    if (idx == '0) begin
                        binary    <= w_next;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        idx <= idx - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    idx       <= '0;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
